mips_alu_mc: RTL and testbench
==============================

Name: mips_alu_mc

Overview:
- Parametrised multi-cycle ALU for the MIPS datapath.
- Executes all R-type and I-type ALU ops of the single-cycle ALU, registered, plus iterative mult/multu/div/divu into HI/LO and mfhi/mflo reads.
- Sits between the register-read stage and writeback; a valid/ready handshake lets the control unit stall while a multiply or divide iterates.

Parameters:
WIDTH, 32, datapath width in bits (even, >=8)
SHW, $clog2(WIDTH), shift-amount width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation presented
in_ready  out  1  ALU can accept; transfer when in_valid && in_ready
op  in  6  MIPS opcode
func  in  6  MIPS funct (used when op==000000)
shamt  in  SHW  shift amount
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand or extended immediate
out_valid  out  1  one-cycle pulse: result/hi/lo valid
result  out  WIDTH  GPR result
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
illegal  out  1  with out_valid: unsupported op/func, result=0

Behaviour:
- Reset: all outputs 0 except in_ready=1; state IDLE; HI/LO and iteration registers cleared. Reset mid-operation aborts it and produces no out_valid.
- States IDLE, MUL, DIV. in_ready = (state==IDLE).
- Single-cycle ops (accepted in IDLE): result registered, out_valid the cycle after acceptance; in_ready stays 1, so back-to-back issue is allowed.
  - R-type: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), sltu 101011 (unsigned), sll 000000, srl 000010, sra 000011 (shift b by shamt).
  - mfhi 010000 / mflo 010010 return the current HI/LO.
  - I-type: addi 001000, addiu 001001, andi 001100, ori 001101, slti 001010 (signed), sltiu 001011 (unsigned), lui 001111 (b<<16).
  - All arithmetic wraps modulo 2^WIDTH; no overflow trap.
- Multi-cycle ops:
  - mult 011000 / multu 011001: shift-add, one bit per cycle. Signed forms take magnitudes and negate the 2*WIDTH product at the end.
  - div 011010 / divu 011011: restoring division, one quotient bit per cycle. Signed div truncates toward zero; remainder takes the dividend's sign.
  - Timing: accept at cycle 0; state MUL/DIV for cycles 1..WIDTH; HI/LO updated and out_valid pulsed at cycle WIDTH+1, state back to IDLE in the same cycle. in_ready is 0 for cycles 1..WIDTH and 1 at WIDTH+1, so the next op may be accepted while out_valid pulses.
  - result=0 for mult/div. HI=upper/remainder, LO=lower/quotient.
- Divide by zero: HI=a, LO=all ones, no exception, normal latency.
- Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- in_valid while in_ready=0 is ignored; the operands are not captured.
- Illegal op/func: out_valid next cycle, illegal=1, result=0; HI/LO unchanged.
- HI/LO change only on completion of mult/div or on reset.
- result and hi/lo hold their last values between pulses.

Decomposition:
- Shared package mips_alu_pkg holds the localparams for opcodes, funct codes and FSM state encodings, also used by the control unit.
- One sub-module, mips_muldiv_iter: owns the MUL/DIV iteration registers and counter; start/done interface with signed/unsigned and mul/div selects.
- Single-cycle logic stays in the top module.

Test Plan:
- WIDTH=32: add a=7,b=-3 -> result=4, out_valid 1 cycle later; back-to-back sltu a=1,b=0xFFFFFFFF -> 1; slt same operands -> 0.
- sra b=0x80000000, shamt=4 -> 0xF8000000; srl same -> 0x08000000; lui b=0x1234 -> 0x12340000.
- mult a=-3,b=5 -> out_valid at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFF1; in_ready low cycles 1..32; a stray in_valid at cycle 10 is ignored.
- div a=-7,b=2 -> LO=-3, HI=-1; divu a=7,b=0 -> HI=7, LO=0xFFFFFFFF; then mfhi -> 7.
- reset asserted at cycle 15 of divu -> no out_valid, HI=LO=0, in_ready=1 immediately; then op=111111 -> illegal=1, result=0.
- WIDTH=16: multu a=0xFFFF,b=0xFFFF -> HI=0xFFFE, LO=0x0001 at cycle 17.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg
// Shared constants for the multi-cycle MIPS ALU and the control unit:
// opcode and funct encodings the ALU understands, plus the FSM state type.
// No ports; import with "import mips_alu_pkg::*;".
package mips_alu_pkg;

    // Primary opcodes (instruction bits 31:26)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Funct codes (instruction bits 5:0) used when op is OP_RTYPE
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // ALU sequencing states; IDLE is the only state that accepts work
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } aluState_e;

endpackage

// File: rtl/mips_alu_mc_if.sv
// mips_alu_mc_if
// Issue/result bundle between the register-read stage and the ALU.
//   master : drives in_valid, op, func, shamt, a, b; sees the rest
//   slave  : the ALU; drives in_ready, out_valid, result, hi, lo, illegal
interface mips_alu_mc_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op;
    logic [5:0]       func;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             illegal;

    modport master (
        output in_valid, op, func, shamt, a, b,
        input  in_ready, out_valid, result, hi, lo, illegal
    );

    modport slave (
        input  in_valid, op, func, shamt, a, b,
        output in_ready, out_valid, result, hi, lo, illegal
    );
endinterface

// File: rtl/mips_muldiv_iter.sv
// mips_muldiv_iter
// Iterative multiply (shift-add) and restoring divide, one bit per cycle.
// Ports:
//   clk, reset     clock, async active-high reset
//   start_i        load operands and begin WIDTH iterations
//   isDiv_i        1 = divide, 0 = multiply
//   isSigned_i     treat a_i/b_i as two's complement
//   a_i, b_i       operands (dividend/divisor or multiplicands)
//   done_o         high during the last iteration cycle; hi_o/lo_o are
//                  the final values to be captured at that clock edge
//   hi_o, lo_o     product upper/lower, or remainder/quotient
module mips_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             isDiv_i,
    input  logic             isSigned_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    logic               busy_q;
    logic               isDiv_q;
    logic               negMain_q;
    logic               negRem_q;
    logic [SHW-1:0]     count_q;
    logic [WIDTH-1:0]   operand_q;
    logic [2*WIDTH-1:0] prod_q;

    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [2*WIDTH-1:0] prod_d;
    logic [2*WIDTH-1:0] signedProd;

    assign aNeg = isSigned_i & a_i[WIDTH-1];
    assign bNeg = isSigned_i & b_i[WIDTH-1];
    assign aMag = aNeg ? -a_i : a_i;
    assign bMag = bNeg ? -b_i : b_i;

    // One iteration step on prod_q.
    // Multiply: upper half accumulates the multiplicand when the LSB of the
    // multiplier is set, then the whole register shifts right.
    // Divide: upper half is the partial remainder, lower half the dividend
    // that gets replaced bit by bit with quotient bits from the right.
    always_comb begin
        mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
        divShift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        divDiff  = divShift - {1'b0, operand_q};
        if (isDiv_q) begin
            if (divDiff[WIDTH]) begin
                prod_d = {divShift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            end else begin
                prod_d = {divDiff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            prod_d = {mulSum, prod_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied to the value produced by the final step so the
    // parent can register HI/LO at the same edge the last bit is formed.
    always_comb begin
        signedProd = negMain_q ? -prod_d : prod_d;
        if (isDiv_q) begin
            hi_o = negRem_q  ? -prod_d[2*WIDTH-1:WIDTH] : prod_d[2*WIDTH-1:WIDTH];
            lo_o = negMain_q ? -prod_d[WIDTH-1:0]       : prod_d[WIDTH-1:0];
        end else begin
            hi_o = signedProd[2*WIDTH-1:WIDTH];
            lo_o = signedProd[WIDTH-1:0];
        end
    end

    assign done_o = busy_q && (count_q == LAST_STEP);

    // Operand capture on start, then WIDTH steps. A zero divisor yields an
    // all-ones quotient and remainder |a|; leaving the quotient un-negated
    // keeps LO all ones for signed divides too, while the remainder sign
    // fix-up restores HI to the original a.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            isDiv_q   <= 1'b0;
            negMain_q <= 1'b0;
            negRem_q  <= 1'b0;
            count_q   <= '0;
            operand_q <= '0;
            prod_q    <= '0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            isDiv_q   <= isDiv_i;
            negMain_q <= isDiv_i ? ((aNeg ^ bNeg) && (b_i != '0)) : (aNeg ^ bNeg);
            negRem_q  <= aNeg;
            count_q   <= '0;
            operand_q <= bMag;
            prod_q    <= {{WIDTH{1'b0}}, aMag};
        end else if (busy_q) begin
            prod_q  <= prod_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_STEP) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_alu_mc.sv
// mips_alu_mc
// Multi-cycle MIPS ALU: registered single-cycle R/I-type ops plus
// iterative mult/multu/div/divu into HI/LO, with a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    mips_alu_mc_if slave: in_valid/in_ready, op, func, shamt, a, b
//          in; out_valid pulse with result, hi, lo, illegal out
module mips_alu_mc
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    mips_alu_mc_if.slave  bus
);

    aluState_e        state_q;
    logic             outValid_q;
    logic             illegal_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic [WIDTH-1:0] result_d;
    logic             illegal_d;
    logic             startMul;
    logic             startDiv;
    logic             signedOp;
    logic             iterDone;
    logic [WIDTH-1:0] iterHi;
    logic [WIDTH-1:0] iterLo;

    assign accept        = bus.in_valid && (state_q == IDLE);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = outValid_q;
    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.illegal   = illegal_q;

    // Decode and single-cycle datapath. Immediates arrive already extended
    // in b, so I-type ops reuse the R-type arithmetic.
    always_comb begin
        result_d  = '0;
        illegal_d = 1'b0;
        startMul  = 1'b0;
        startDiv  = 1'b0;
        signedOp  = 1'b0;
        if (bus.op == OP_RTYPE) begin
            case (bus.func)
                FN_ADD:   result_d = bus.a + bus.b;
                FN_SUB:   result_d = bus.a - bus.b;
                FN_AND:   result_d = bus.a & bus.b;
                FN_OR:    result_d = bus.a | bus.b;
                FN_SLT:   result_d = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
                FN_SLTU:  result_d = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
                FN_SLL:   result_d = bus.b << bus.shamt;
                FN_SRL:   result_d = bus.b >> bus.shamt;
                FN_SRA:   result_d = $signed(bus.b) >>> bus.shamt;
                FN_MFHI:  result_d = hi_q;
                FN_MFLO:  result_d = lo_q;
                FN_MULT:  begin startMul = 1'b1; signedOp = 1'b1; end
                FN_MULTU: startMul = 1'b1;
                FN_DIV:   begin startDiv = 1'b1; signedOp = 1'b1; end
                FN_DIVU:  startDiv = 1'b1;
                default:  illegal_d = 1'b1;
            endcase
        end else begin
            case (bus.op)
                OP_ADDI, OP_ADDIU: result_d = bus.a + bus.b;
                OP_ANDI:  result_d = bus.a & bus.b;
                OP_ORI:   result_d = bus.a | bus.b;
                OP_SLTI:  result_d = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
                OP_SLTIU: result_d = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
                OP_LUI:   result_d = bus.b << 16;
                default:  illegal_d = 1'b1;
            endcase
        end
    end

    mips_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk        (clk),
        .reset      (reset),
        .start_i    (accept && (startMul || startDiv)),
        .isDiv_i    (startDiv),
        .isSigned_i (signedOp),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .done_o     (iterDone),
        .hi_o       (iterHi),
        .lo_o       (iterLo)
    );

    // Sequencer with registered outputs. Single-cycle ops complete from
    // IDLE and keep it; mul/div park in MUL/DIV until the iterator's last
    // step, which returns to IDLE in the same edge that posts HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            illegal_q  <= 1'b0;
            result_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && startMul) begin
                        state_q    <= MUL;
                        outValid_q <= 1'b0;
                    end else if (accept && startDiv) begin
                        state_q    <= DIV;
                        outValid_q <= 1'b0;
                    end else if (accept) begin
                        outValid_q <= 1'b1;
                        result_q   <= result_d;
                        illegal_q  <= illegal_d;
                    end else begin
                        outValid_q <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    if (iterDone) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b1;
                        result_q   <= '0;
                        illegal_q  <= 1'b0;
                        hi_q       <= iterHi;
                        lo_q       <= iterLo;
                    end else begin
                        outValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_mc.sv
// tb_mips_alu_mc
// Self-checking bench: a 32-bit ALU driven from a vector table through a
// scoreboard queue, hand sequences for mult stalling and reset abort, and
// a 16-bit instance for the narrow multu case.
module tb_mips_alu_mc;
    import mips_alu_pkg::*;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  shamt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill;
        int          issue;
        int          lat;
        int          tag;
    } exp_t;

    logic clk;
    logic reset;
    int   cycle = 0;
    int   errors = 0;
    int   checks = 0;
    int   phaseOneEnd;
    vec_t vecs[$];
    exp_t sbQ[$];

    mips_alu_mc_if #(.WIDTH(32)) bus32();
    mips_alu_mc_if #(.WIDTH(16)) bus16();

    mips_alu_mc #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    mips_alu_mc #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    // Free-running clock and cycle counter used for latency checks
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string what, input int tag,
                               input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (tag %0d): got 0x%0h, expected 0x%0h", what, tag, act, exp);
        end
    endtask

    function automatic void addVec(input logic [5:0] op, input logic [5:0] func,
                                   input logic [4:0] shamt, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] res,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   input logic ill);
        vec_t v;
        v.op = op; v.func = func; v.shamt = shamt; v.a = a; v.b = b;
        v.res = res; v.hi = hi; v.lo = lo; v.ill = ill;
        v.lat = (op == 6'b000000 && func[5:2] == 4'b0110) ? 33 : 1;
        vecs.push_back(v);
    endfunction

    task automatic waitReady();
        int n = 0;
        while (!bus32.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus32.in_ready) checkOutput("readyTimeout", -1, 64'(0), 64'(1));
    endtask

    task automatic applyStimulus(input int idx);
        exp_t e;
        waitReady();
        bus32.op       = vecs[idx].op;
        bus32.func     = vecs[idx].func;
        bus32.shamt    = vecs[idx].shamt;
        bus32.a        = vecs[idx].a;
        bus32.b        = vecs[idx].b;
        bus32.in_valid = 1'b1;
        e.res = vecs[idx].res; e.hi = vecs[idx].hi; e.lo = vecs[idx].lo;
        e.ill = vecs[idx].ill; e.lat = vecs[idx].lat;
        e.issue = cycle; e.tag = idx;
        sbQ.push_back(e);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drainQueue", -1, 64'(sbQ.size()), 64'(0));
    endtask

    // Scoreboard: every out_valid pulse pops the oldest expectation
    always @(negedge clk) begin
        if (!reset && bus32.out_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedOutValid", -1, 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("latency", e.tag, 64'(cycle - e.issue), 64'(e.lat));
                checkOutput("result",  e.tag, 64'(bus32.result),  64'(e.res));
                checkOutput("hi",      e.tag, 64'(bus32.hi),      64'(e.hi));
                checkOutput("lo",      e.tag, 64'(bus32.lo),      64'(e.lo));
                checkOutput("illegal", e.tag, 64'(bus32.illegal), 64'(e.ill));
            end
        end
    end

    initial begin
        int lowCount;
        int n;

        reset = 1'b1;
        bus32.in_valid = 1'b0; bus32.op = '0; bus32.func = '0;
        bus32.shamt = '0; bus32.a = '0; bus32.b = '0;
        bus16.in_valid = 1'b0; bus16.op = '0; bus16.func = '0;
        bus16.shamt = '0; bus16.a = '0; bus16.b = '0;

        //      op        func      sh     a             b             result        hi            lo            ill
        addVec(OP_RTYPE, FN_ADD,   5'd0,  32'd7,        32'hFFFFFFFD, 32'd4,        32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_SLTU,  5'd0,  32'd1,        32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_SLT,   5'd0,  32'd1,        32'hFFFFFFFF, 32'd0,        32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_SUB,   5'd0,  32'd5,        32'd8,        32'hFFFFFFFD, 32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_AND,   5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_OR,    5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_SRA,   5'd4,  32'd0,        32'h80000000, 32'hF8000000, 32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_SRL,   5'd4,  32'd0,        32'h80000000, 32'h08000000, 32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_SLL,   5'd31, 32'd0,        32'h00000001, 32'h80000000, 32'h0,        32'h0,        1'b0);
        addVec(OP_LUI,   6'd0,     5'd0,  32'd0,        32'h00001234, 32'h12340000, 32'h0,        32'h0,        1'b0);
        addVec(OP_ADDI,  6'd0,     5'd0,  32'd10,       32'hFFFFFFFF, 32'd9,        32'h0,        32'h0,        1'b0);
        addVec(OP_ADDIU, 6'd0,     5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        32'h0,        1'b0);
        addVec(OP_ANDI,  6'd0,     5'd0,  32'h12345678, 32'h0000FFFF, 32'h00005678, 32'h0,        32'h0,        1'b0);
        addVec(OP_ORI,   6'd0,     5'd0,  32'h12340000, 32'h00005678, 32'h12345678, 32'h0,        32'h0,        1'b0);
        addVec(OP_SLTI,  6'd0,     5'd0,  32'hFFFFFFFE, 32'd1,        32'd1,        32'h0,        32'h0,        1'b0);
        addVec(OP_SLTIU, 6'd0,     5'd0,  32'hFFFFFFFE, 32'd1,        32'd0,        32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_ADD,   5'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 32'h0,        32'h0,        1'b0);
        addVec(OP_RTYPE, FN_DIV,   5'd0,  32'hFFFFFFF9, 32'd2,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        addVec(OP_RTYPE, FN_DIVU,  5'd0,  32'd7,        32'd0,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b0);
        addVec(OP_RTYPE, FN_MFHI,  5'd0,  32'd0,        32'd0,        32'd7,        32'd7,        32'hFFFFFFFF, 1'b0);
        addVec(OP_RTYPE, FN_MFLO,  5'd0,  32'd0,        32'd0,        32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 1'b0);
        addVec(OP_RTYPE, FN_DIV,   5'd0,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h0,        32'h80000000, 1'b0);
        addVec(OP_RTYPE, FN_MULTU, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 32'h00000001, 1'b0);
        addVec(OP_RTYPE, FN_DIV,   5'd0,  32'hFFFFFFF9, 32'd0,        32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
        addVec(OP_RTYPE, FN_DIVU,  5'd0,  32'd100,      32'd7,        32'd0,        32'd2,        32'd14,       1'b0);
        addVec(OP_RTYPE, FN_MULT,  5'd0,  32'h80000000, 32'd2,        32'd0,        32'hFFFFFFFF, 32'h0,        1'b0);
        addVec(6'b111111, 6'd0,    5'd0,  32'd5,        32'd6,        32'd0,        32'hFFFFFFFF, 32'h0,        1'b1);
        addVec(OP_RTYPE, 6'b000001,5'd0,  32'd5,        32'd6,        32'd0,        32'hFFFFFFFF, 32'h0,        1'b1);
        addVec(OP_RTYPE, FN_SRA,   5'd4,  32'd0,        32'h7FFFFFF0, 32'h07FFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0);
        phaseOneEnd = vecs.size();
        // Issued after the reset abort, so HI/LO are back to zero
        addVec(OP_RTYPE, FN_MFHI,  5'd0,  32'd0,        32'd0,        32'd0,        32'h0,        32'h0,        1'b0);
        addVec(6'b111111, 6'd0,    5'd0,  32'd5,        32'd6,        32'd0,        32'h0,        32'h0,        1'b1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetInReady",  -1, 64'(bus32.in_ready),  64'(1));
        checkOutput("resetOutValid", -1, 64'(bus32.out_valid), 64'(0));
        checkOutput("resetResult",   -1, 64'(bus32.result),    64'(0));
        checkOutput("resetHi",       -1, 64'(bus32.hi),        64'(0));
        checkOutput("resetLo",       -1, 64'(bus32.lo),        64'(0));
        checkOutput("resetIllegal",  -1, 64'(bus32.illegal),   64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < phaseOneEnd; i++) applyStimulus(i);
        drain();

        // mult -3 * 5 with a stray in_valid while the ALU is busy
        begin
            exp_t e;
            waitReady();
            bus32.op = OP_RTYPE; bus32.func = FN_MULT; bus32.shamt = '0;
            bus32.a = 32'hFFFFFFFD; bus32.b = 32'd5; bus32.in_valid = 1'b1;
            e.res = 32'd0; e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFF1; e.ill = 1'b0;
            e.issue = cycle; e.lat = 33; e.tag = 100;
            sbQ.push_back(e);
            @(posedge clk); #1;
            bus32.in_valid = 1'b0;
            lowCount = 0;
            for (int c = 1; c <= 32; c++) begin
                if (!bus32.in_ready) lowCount++;
                if (c == 10) begin
                    bus32.func = FN_ADD; bus32.a = 32'd1; bus32.b = 32'd1;
                    bus32.in_valid = 1'b1;
                end
                @(posedge clk); #1;
                bus32.in_valid = 1'b0;
            end
            checkOutput("readyLowCycles", 100, 64'(lowCount), 64'(32));
            checkOutput("readyAtDone",    100, 64'(bus32.in_ready), 64'(1));
        end
        drain();

        // Reset during divu aborts it with no result
        waitReady();
        bus32.op = OP_RTYPE; bus32.func = FN_DIVU; bus32.a = 32'd7; bus32.b = 32'd0;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checkOutput("abortInReady",  200, 64'(bus32.in_ready),  64'(1));
        checkOutput("abortHi",       200, 64'(bus32.hi),        64'(0));
        checkOutput("abortLo",       200, 64'(bus32.lo),        64'(0));
        checkOutput("abortOutValid", 200, 64'(bus32.out_valid), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        checkOutput("hiAfterAbort", 200, 64'(bus32.hi), 64'(0));

        for (int i = phaseOneEnd; i < vecs.size(); i++) applyStimulus(i);
        drain();

        // 16-bit multu 0xFFFF * 0xFFFF
        bus16.op = OP_RTYPE; bus16.func = FN_MULTU; bus16.shamt = '0;
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        n = 1;
        while (!bus16.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("w16Latency", 300, 64'(n),             64'(17));
        checkOutput("w16Hi",      300, 64'(bus16.hi),      64'(16'hFFFE));
        checkOutput("w16Lo",      300, 64'(bus16.lo),      64'(16'h0001));
        checkOutput("w16Result",  300, 64'(bus16.result),  64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
